uart_receiver: RTL

- Receive-side counterpart of the team's `uart_transmitter`; deserialises its line format back into bytes.
- Line format: idle high, one start bit (0), DATA_BITS data bits MSB first, one stop bit (1).
- Default timing is one bit per CLK, so it loops back directly against the transmitter. CLKS_PER_BIT>1 gives mid-bit sampling of slower lines.
- Sits on the serial input of the benchmark UART path; presents each received word with a one-cycle valid strobe.

---
 rtl/uart_receiver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART receiver: idle-high line, one start bit, DATA_BITS data bits MSB first, one stop bit.
// Oversampled by CLKS_PER_BIT; with one clock per bit it loops back directly against uart_transmitter.
module uart_receiver #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [IW-1:0] IDX_TOP  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q;

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= IDX_ZERO;
      shift_q <= {DATA_BITS{1'b0}};
      data_q  <= {DATA_BITS{1'b0}};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx) begin
          idx_d = IDX_TOP;
          // At one clock per bit the start-bit cycle itself is the start sample.
          if (CLKS_PER_BIT == 1) begin
            state_d = ST_DATA;
            cnt_d   = CNT_BIT;
          end else begin
            state_d = ST_START;
            cnt_d   = CNT_HALF;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx) begin
          state_d = ST_DATA;
          cnt_d   = CNT_BIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = DATA_BITS'({shift_q, rx});
          cnt_d   = CNT_BIT;
          if (idx_q == IDX_ZERO) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      ST_STOP: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign busy          = busy_q;

endmodule
